// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the mips memory-side responder.
// MMIO decode constants are only consumed when MIPS_MMIO_EN is defined.
package mips_mem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } mem_state_t;

  localparam logic [31:0] MMIO_BASE    = 32'hFFFF0000;
  localparam logic [15:0] MMIO_CYCLES  = 16'h0000;
  localparam logic [15:0] MMIO_LED     = 16'h0004;
  localparam logic [15:0] MMIO_LOADCNT = 16'h0008;
  localparam logic [31:0] NOP_WORD     = 32'h0;

  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[31:16] == MMIO_BASE[31:16];
  endfunction

endpackage

// File: rtl/mips_mmio_regs.sv
// MMIO register block: free-running RUN cycle counter, LED register and read mux.
// Only instantiated by mips_mem_sys when MIPS_MMIO_EN is defined.
module mips_mmio_regs
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        wr_en,
  input  logic [15:0] offset,
  input  logic [31:0] writedata,
  input  logic [31:0] load_count,
  output logic [31:0] rdata,
  output logic [7:0]  led
);

  logic [31:0] cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles <= 32'h0;
      led    <= 8'h0;
    end else begin
      if (run) cycles <= cycles + 32'd1;
      if (wr_en && offset == MMIO_LED) led <= writedata[7:0];
    end
  end

  // Exact offset match; everything else in the window reads as zero.
  always_comb begin
    rdata = 32'h0;
    case (offset)
      MMIO_CYCLES:  rdata = cycles;
      MMIO_LED:     rdata = {24'h0, led};
      MMIO_LOADCNT: rdata = load_count;
      default:      rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/mips_mem_sys.sv
// Instruction/data memory responder for the single-cycle mips core with a boot-load port.
// Define MIPS_MMIO_EN to add the MMIO window (cycle counter, LED register, load count).
module mips_mem_sys
  import mips_mem_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_hold,
  output logic [7:0]  led
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  mem_state_t     state;
  logic [IAW:0]   load_ptr;
  logic [31:0]    imem [IMEM_DEPTH];
  logic [31:0]    dmem [DMEM_DEPTH];
  logic [DAW-1:0] dmem_idx;
  logic           run;
  logic           accept;
  logic           mmio_sel;
  logic [31:0]    mmio_rdata;

  assign run      = (state == RUN);
  assign accept   = load_ready && load_valid;
  assign dmem_idx = aluout[DAW+1:2];

  // load_ptr carries one extra bit so a full-depth load reports IMEM_DEPTH words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      load_ptr   <= '0;
      load_ready <= 1'b1;
    end else if (accept) begin
      load_ptr <= load_ptr + 1'b1;
      if (load_last || load_ptr == (IAW+1)'(IMEM_DEPTH - 1)) begin
        state      <= RUN;
        load_ready <= 1'b0;
      end
    end
  end

  assign cpu_hold = load_ready;

  always_ff @(posedge clk) begin
    if (accept) imem[load_ptr[IAW-1:0]] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (run && memwrite && !mmio_sel) dmem[dmem_idx] <= writedata;
  end

`ifdef MIPS_MMIO_EN
  assign mmio_sel = is_mmio(aluout);

  mips_mmio_regs u_mmio_regs (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .wr_en      (run && memwrite && mmio_sel),
    .offset     (aluout[15:0]),
    .writedata  (writedata),
    .load_count (32'(load_ptr)),
    .rdata      (mmio_rdata),
    .led        (led)
  );
`else
  assign mmio_sel   = 1'b0;
  assign mmio_rdata = 32'h0;
  assign led        = 8'h0;
`endif

  assign instr    = run ? imem[pc[IAW+1:2]] : NOP_WORD;
  assign readdata = !run    ? NOP_WORD :
                    mmio_sel ? mmio_rdata : dmem[dmem_idx];

  // Address bits outside the index fields alias by design.
  logic unused_bits;
  assign unused_bits = ^{pc[31:IAW+2], pc[1:0], aluout[31:DAW+2], aluout[1:0]};

endmodule
